// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit: condition codes,
// NZCV bit positions and default sizing.
package cond_pkg;

    localparam int COND_W          = 4;
    localparam int NUM_FLAGS_DEF   = 4;
    localparam int FLAG_GROUPS_DEF = 2;
    localparam int STAT_W          = 16;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    typedef enum logic [COND_W-1:0] {
        EQ = 4'h0,
        NE = 4'h1,
        CS = 4'h2,
        CC = 4'h3,
        MI = 4'h4,
        PL = 4'h5,
        VS = 4'h6,
        VC = 4'h7,
        HI = 4'h8,
        LS = 4'h9,
        GE = 4'hA,
        LT = 4'hB,
        GT = 4'hC,
        LE = 4'hD,
        AL = 4'hE,
        NV = 4'hF
    } cond_code_e;

endpackage

// File: rtl/cond_logic_pipe_eval.sv
// Combinational ARM condition-code evaluator: decides whether an instruction
// with the given condition field executes under the current NZCV flags.
module cond_eval
    import cond_pkg::*;
#(
    parameter int NUM_FLAGS = NUM_FLAGS_DEF
) (
    input  logic [COND_W-1:0]    cond,
    input  logic [NUM_FLAGS-1:0] flags,
    output logic                 pass
);

    logic n_f;
    logic z_f;
    logic c_f;
    logic v_f;

    assign n_f = flags[N_BIT];
    assign z_f = flags[Z_BIT];
    assign c_f = flags[C_BIT];
    assign v_f = flags[V_BIT];

    always_comb begin
        pass = 1'b1;
        case (cond_code_e'(cond))
            EQ:      pass = z_f;
            NE:      pass = ~z_f;
            CS:      pass = c_f;
            CC:      pass = ~c_f;
            MI:      pass = n_f;
            PL:      pass = ~n_f;
            VS:      pass = v_f;
            VC:      pass = ~v_f;
            HI:      pass = c_f & ~z_f;
            LS:      pass = ~c_f | z_f;
            GE:      pass = (n_f == v_f);
            LT:      pass = (n_f != v_f);
            GT:      pass = ~z_f & (n_f == v_f);
            LE:      pass = z_f | (n_f != v_f);
            // NV is treated as unconditional, same as AL.
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_logic_pipe.sv
// Execute-stage conditional-execution unit: owns NZCV plus a shadow copy,
// gates the instruction's side effects and registers them into Memory.
// Optional build macro COND_STATS_EN adds saturating exec/squash counters.
module cond_logic_pipe
    import cond_pkg::*;
#(
    parameter int NUM_FLAGS   = NUM_FLAGS_DEF,
    parameter int FLAG_GROUPS = FLAG_GROUPS_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   flush_e,
    input  logic                   pc_src_e,
    input  logic                   reg_write_e,
    input  logic                   mem_write_e,
    input  logic [FLAG_GROUPS-1:0] flag_write_e,
    input  logic [COND_W-1:0]      cond_e,
    input  logic [NUM_FLAGS-1:0]   alu_flags,
    input  logic                   save_flags,
    input  logic                   restore_flags,
    output logic                   cond_ex_e,
    output logic                   pc_src_taken_e,
    output logic                   pc_src_m,
    output logic                   reg_write_m,
    output logic                   mem_write_m,
    output logic [NUM_FLAGS-1:0]   flags,
    output logic [NUM_FLAGS-1:0]   shadow_flags
`ifdef COND_STATS_EN
    ,
    output logic [STAT_W-1:0]      exec_cnt,
    output logic [STAT_W-1:0]      squash_cnt
`endif
);

    localparam int GW = NUM_FLAGS / FLAG_GROUPS;

    logic                   cond_pass;
    logic                   pc_src_p0;
    logic                   reg_write_p0;
    logic                   mem_write_p0;
    logic [FLAG_GROUPS-1:0] fw_p0;
    logic [NUM_FLAGS-1:0]   flags_q;
    logic [NUM_FLAGS-1:0]   shadow_q;

    cond_eval #(
        .NUM_FLAGS (NUM_FLAGS)
    ) u_cond_eval (
        .cond  (cond_e),
        .flags (flags_q),
        .pass  (cond_pass)
    );

    // ---- Execute stage: condition check and side-effect gating ----
    assign cond_ex_e      = cond_pass & ~flush_e;
    assign pc_src_taken_e = pc_src_e & cond_ex_e;

    assign pc_src_p0    = pc_src_e & cond_ex_e;
    assign reg_write_p0 = reg_write_e & cond_ex_e;
    assign mem_write_p0 = mem_write_e & cond_ex_e;
    assign fw_p0        = flag_write_e & {FLAG_GROUPS{cond_ex_e}};

    // ---- Execute -> Memory boundary ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_src_m    <= 1'b0;
            reg_write_m <= 1'b0;
            mem_write_m <= 1'b0;
        end else if (en) begin
            pc_src_m    <= pc_src_p0;
            reg_write_m <= reg_write_p0;
            mem_write_m <= mem_write_p0;
        end
    end

    // Restore outranks any group write; untouched groups hold their value.
    for (genvar g = 0; g < FLAG_GROUPS; g++) begin : g_flag_grp
        logic [GW-1:0] grp_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                grp_q <= '0;
            end else if (en) begin
                if (restore_flags) begin
                    grp_q <= shadow_q[g*GW +: GW];
                end else if (fw_p0[g]) begin
                    grp_q <= alu_flags[g*GW +: GW];
                end
            end
        end

        assign flags_q[g*GW +: GW] = grp_q;
    end

    // Shadow samples the pre-edge flags, so save+restore naturally swaps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
        end else if (en && save_flags) begin
            shadow_q <= flags_q;
        end
    end

    assign flags        = flags_q;
    assign shadow_flags = shadow_q;

`ifdef COND_STATS_EN
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [STAT_W-1:0] exec_q;
    logic [STAT_W-1:0] squash_q;

    // Bubbles are neither executed nor squashed, so they are not counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exec_q   <= '0;
            squash_q <= '0;
        end else if (en && !flush_e) begin
            if (cond_ex_e) begin
                exec_q <= sat_inc(exec_q);
            end else begin
                squash_q <= sat_inc(squash_q);
            end
        end
    end

    assign exec_cnt   = exec_q;
    assign squash_cnt = squash_q;
`endif

endmodule

// File: tb/tb_cond_logic_pipe.sv
// Directed bench for cond_logic_pipe: condition table, gating, stall/flush,
// shadow save/restore/swap and asynchronous reset.
module tb_cond_logic_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       flush_e;
    logic       pc_src_e;
    logic       reg_write_e;
    logic       mem_write_e;
    logic [1:0] flag_write_e;
    logic [3:0] cond_e;
    logic [3:0] alu_flags;
    logic       save_flags;
    logic       restore_flags;
    logic       cond_ex_e;
    logic       pc_src_taken_e;
    logic       pc_src_m;
    logic       reg_write_m;
    logic       mem_write_m;
    logic [3:0] flags;
    logic [3:0] shadow_flags;
`ifdef COND_STATS_EN
    logic [15:0] exec_cnt;
    logic [15:0] squash_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cond_logic_pipe dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .flush_e        (flush_e),
        .pc_src_e       (pc_src_e),
        .reg_write_e    (reg_write_e),
        .mem_write_e    (mem_write_e),
        .flag_write_e   (flag_write_e),
        .cond_e         (cond_e),
        .alu_flags      (alu_flags),
        .save_flags     (save_flags),
        .restore_flags  (restore_flags),
        .cond_ex_e      (cond_ex_e),
        .pc_src_taken_e (pc_src_taken_e),
        .pc_src_m       (pc_src_m),
        .reg_write_m    (reg_write_m),
        .mem_write_m    (mem_write_m),
        .flags          (flags),
        .shadow_flags   (shadow_flags)
`ifdef COND_STATS_EN
        ,
        .exec_cnt       (exec_cnt),
        .squash_cnt     (squash_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] pass_mask;

    initial begin
        reset = 1'b0; en = 1'b0; flush_e = 1'b0; pc_src_e = 1'b0;
        reg_write_e = 1'b0; mem_write_e = 1'b0; flag_write_e = 2'b00;
        cond_e = 4'hE; alu_flags = 4'h0; save_flags = 1'b0; restore_flags = 1'b0;
        tick();
        tick();
        chk("rst_flags",  {12'h0, flags}, 16'h0);
        chk("rst_shadow", {12'h0, shadow_flags}, 16'h0);
        chk("rst_m", {13'h0, pc_src_m, reg_write_m, mem_write_m}, 16'h0);
        reset = 1'b1;

        // AL passes, register write reaches M one cycle later
        en = 1'b1; cond_e = 4'hE; reg_write_e = 1'b1;
        #1 chk("al_cond_ex", {15'h0, cond_ex_e}, 16'h1);
        tick();
        chk("al_reg_write_m", {15'h0, reg_write_m}, 16'h1);
        chk("al_flags", {12'h0, flags}, 16'h0);

        // group 0 (CV) write only
        reg_write_e = 1'b0; flag_write_e = 2'b01; alu_flags = 4'b1111;
        tick();
        chk("grp0_flags", {12'h0, flags}, 16'h0003);

        // EQ fails with Z=0
        flag_write_e = 2'b00; cond_e = 4'h0; mem_write_e = 1'b1;
        #1 chk("eq_cond_ex", {15'h0, cond_ex_e}, 16'h0);
        tick();
        chk("eq_mem_write_m", {15'h0, mem_write_m}, 16'h0);
        mem_write_e = 1'b0;

        // full condition table against N=0 Z=0 C=1 V=1
        pass_mask = 16'hE966;
        for (int i = 0; i < 16; i++) begin
            cond_e = i[3:0];
            #1 chk($sformatf("cond_tbl_%0h", i), {15'h0, cond_ex_e}, {15'h0, pass_mask[i]});
        end

        // load M-stage outputs, then stall with a pending flag write
        cond_e = 4'hE; reg_write_e = 1'b1; mem_write_e = 1'b1;
        tick();
        en = 1'b0; flag_write_e = 2'b11; alu_flags = 4'b1100;
        reg_write_e = 1'b0; mem_write_e = 1'b0;
        tick();
        chk("stall_flags", {12'h0, flags}, 16'h0003);
        chk("stall_m", {14'h0, reg_write_m, mem_write_m}, 16'h0003);

        // flushed branch
        en = 1'b1; flush_e = 1'b1; pc_src_e = 1'b1;
        #1 chk("flush_taken", {15'h0, pc_src_taken_e}, 16'h0);
        tick();
        chk("flush_pc_src_m", {15'h0, pc_src_m}, 16'h0);
        chk("flush_flags", {12'h0, flags}, 16'h0003);
        chk("flush_reg_write_m", {15'h0, reg_write_m}, 16'h0);

        // unflushed branch
        flush_e = 1'b0; flag_write_e = 2'b00;
        #1 chk("br_taken", {15'h0, pc_src_taken_e}, 16'h1);
        tick();
        chk("br_pc_src_m", {15'h0, pc_src_m}, 16'h1);
        pc_src_e = 1'b0;

        // save / restore, restore beats a simultaneous write
        flag_write_e = 2'b11; alu_flags = 4'b1010;
        tick();
        chk("sr_set", {12'h0, flags}, 16'h000A);
        flag_write_e = 2'b00; save_flags = 1'b1;
        tick();
        chk("sr_saved", {12'h0, shadow_flags}, 16'h000A);
        save_flags = 1'b0; flag_write_e = 2'b11; alu_flags = 4'b0101;
        tick();
        chk("sr_written", {12'h0, flags}, 16'h0005);
        restore_flags = 1'b1; alu_flags = 4'b1111;
        tick();
        chk("sr_restore_wins", {12'h0, flags}, 16'h000A);
        restore_flags = 1'b0;

        // build flags=3, shadow=C, then swap
        alu_flags = 4'hC;
        tick();
        flag_write_e = 2'b00; save_flags = 1'b1;
        tick();
        save_flags = 1'b0; flag_write_e = 2'b11; alu_flags = 4'h3;
        tick();
        chk("swap_pre", {8'h0, flags, shadow_flags}, 16'h003C);
        flag_write_e = 2'b00; save_flags = 1'b1; restore_flags = 1'b1;
        tick();
        chk("swap_post", {8'h0, flags, shadow_flags}, 16'h00C3);

        // save with a concurrent flag write
        restore_flags = 1'b0; flag_write_e = 2'b11; alu_flags = 4'h6;
        tick();
        chk("save_and_write", {8'h0, flags, shadow_flags}, 16'h006C);

        // stalled restore is ignored
        save_flags = 1'b0; flag_write_e = 2'b00; restore_flags = 1'b1; en = 1'b0;
        tick();
        chk("stall_restore", {8'h0, flags, shadow_flags}, 16'h006C);
        restore_flags = 1'b0; en = 1'b1;

        // asynchronous reset mid-cycle
        reg_write_e = 1'b1; mem_write_e = 1'b1; pc_src_e = 1'b1;
        tick();
        chk("pre_async", {13'h0, pc_src_m, reg_write_m, mem_write_m}, 16'h0007);
        #2 reset = 1'b0;
        #1 chk("async_m", {13'h0, pc_src_m, reg_write_m, mem_write_m}, 16'h0);
        chk("async_flags", {8'h0, flags, shadow_flags}, 16'h0);
        reg_write_e = 1'b0; mem_write_e = 1'b0; pc_src_e = 1'b0;
        tick();

`ifdef COND_STATS_EN
        chk("stat_rst", {exec_cnt[7:0], squash_cnt[7:0]}, 16'h0);
        reset = 1'b1;
        cond_e = 4'hE;
        for (int i = 0; i < 3; i++) tick();
        cond_e = 4'h0;
        for (int i = 0; i < 2; i++) tick();
        flush_e = 1'b1;
        tick();
        flush_e = 1'b0;
        chk("stat_exec", exec_cnt, 16'd3);
        chk("stat_squash", squash_cnt, 16'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
